// File: rtl/uart_status_reporter_pkg.sv
// Shared tetris types plus reporter FSM encoding and the nibble-to-ASCII helper.
package enum_type;

    typedef enum logic [3:0] {
        ST_INIT      = 4'h0,
        ST_IDLE      = 4'h1,
        ST_PLAY      = 4'h2,
        ST_MOVE      = 4'h3,
        ST_ROTATE    = 4'h4,
        ST_DROP      = 4'h5,
        ST_LOCK      = 4'h6,
        ST_CLEAR     = 4'h7,
        ST_GAME_OVER = 4'h8
    } state_type;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_SNAP,
        RPT_SEND
    } rpt_state_t;

    // 0-9 -> '0'..'9', A-F -> 'A'..'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end
        return 8'h37 + {4'h0, v};
    endfunction

endpackage

// File: rtl/uart_status_reporter_tx.sv
// 8N1 byte serializer, LSB first; a start accepted on the done cycle gives gap-free frames.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          active_q, active_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic          tx_q, tx_d;
    logic          baud_last;

    assign baud_last = (baud_cnt_q == BAUD_LAST);
    // done marks the final cycle of the stop bit
    assign done      = active_q && (bit_cnt_q == 4'd9) && baud_last;
    assign tx        = tx_q;

    always_comb begin
        active_d   = active_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        tx_d       = tx_q;
        if (start && (!active_q || done)) begin
            active_d   = 1'b1;
            shift_d    = data;
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
            tx_d       = 1'b0;
        end else if (active_q) begin
            if (baud_last) begin
                baud_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else if (bit_cnt_q == 4'd8) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q   <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            active_q   <= active_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: rtl/uart_status_reporter.sv
// Sends "SC=dddd ST=h\r\n" on uart_tx whenever score/state change or send_req pulses.
module uart_status_reporter
    import enum_type::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 115200,
    parameter int MSG_LEN = 14
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic [15:0] score,
    input  state_type state,
    input  logic      send_req,
    output logic      uart_tx,
    output logic      busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    rpt_state_t  state_q, state_d;
    logic [15:0] last_score_q, last_score_d;
    logic [15:0] snap_score_q, snap_score_d;
    logic [3:0]  last_state_q, last_state_d;
    logic [3:0]  snap_state_q, snap_state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic [3:0]  state_low;
    logic        trigger;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  tx_data;

    function automatic logic [7:0] msg_byte(input logic [3:0] i, input logic [15:0] sc,
                                            input logic [3:0] st);
        case (i)
            4'd0:    return 8'h53;
            4'd1:    return 8'h43;
            4'd2:    return 8'h3D;
            4'd3:    return hex_ascii(sc[15:12]);
            4'd4:    return hex_ascii(sc[11:8]);
            4'd5:    return hex_ascii(sc[7:4]);
            4'd6:    return hex_ascii(sc[3:0]);
            4'd7:    return 8'h20;
            4'd8:    return 8'h53;
            4'd9:    return 8'h54;
            4'd10:   return 8'h3D;
            4'd11:   return hex_ascii(st);
            4'd12:   return 8'h0D;
            4'd13:   return 8'h0A;
            default: return 8'h20;
        endcase
    endfunction

    assign state_low = state;
    assign busy      = (state_q != RPT_IDLE);

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        snap_score_d = snap_score_q;
        last_state_d = last_state_q;
        snap_state_d = snap_state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        tx_start     = 1'b0;
        trigger      = send_req | (score != last_score_q) | (state_low != last_state_q);
        case (state_q)
            RPT_IDLE: begin
                if (trigger || pending_q) begin
                    state_d = RPT_SNAP;
                end
            end
            // The values latched here are the new reference, so only send_req can re-arm pending
            RPT_SNAP: begin
                snap_score_d = score;
                snap_state_d = state_low;
                last_score_d = score;
                last_state_d = state_low;
                pending_d    = send_req;
                idx_d        = '0;
                tx_start     = 1'b1;
                state_d      = RPT_SEND;
            end
            RPT_SEND: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = RPT_IDLE;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        tx_start = 1'b1;
                    end
                end
            end
            default: state_d = RPT_IDLE;
        endcase
        // Byte 0 is constant, so the not-yet-latched snapshot during SNAP is harmless
        tx_data = msg_byte(idx_d, snap_score_q, snap_state_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RPT_IDLE;
            last_score_q <= '0;
            snap_score_q <= '0;
            last_state_q <= '0;
            snap_state_q <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            snap_score_q <= snap_score_d;
            last_state_q <= last_state_d;
            snap_state_q <= snap_state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (tx_start),
        .data   (tx_data),
        .tx     (uart_tx),
        .done   (tx_done)
    );

endmodule

// File: tb/tb_uart_status_reporter.sv
// Directed bench: expected bytes queued at stimulus time, popped by a UART frame decoder.
module tb_uart_status_reporter;
    import enum_type::*;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] score    = '0;
    state_type   state    = ST_INIT;
    logic        send_req = 1'b0;
    logic        uart_tx;
    logic        busy;

    int tests  = 0;
    int failed = 0;
    int frames = 0;
    logic [7:0] sb[$];

    uart_status_reporter #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .MSG_LEN(14)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .score   (score),
        .state   (state),
        .send_req(send_req),
        .uart_tx (uart_tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [3:0] n);
        int v;
        v = int'(n);
        return 8'(v < 10 ? 48 + v : 65 + (v - 10));
    endfunction

    function automatic void push_line(input logic [15:0] sc, input logic [3:0] st);
        sb.push_back(8'h53); sb.push_back(8'h43); sb.push_back(8'h3D);
        sb.push_back(exp_char(sc[15:12])); sb.push_back(exp_char(sc[11:8]));
        sb.push_back(exp_char(sc[7:4]));   sb.push_back(exp_char(sc[3:0]));
        sb.push_back(8'h20); sb.push_back(8'h53); sb.push_back(8'h54); sb.push_back(8'h3D);
        sb.push_back(exp_char(st));
        sb.push_back(8'h0D); sb.push_back(8'h0A);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        quiet = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (!busy && uart_tx) quiet++;
            else quiet = 0;
            if (quiet >= 5) break;
        end
        check("idle_reached", 32'(quiet), 32'd5);
    endtask

    // Frame decoder: samples once per clock, 10 samples per bit
    initial begin : monitor
        int         mon_cyc;
        logic [9:0] mon_bits;
        logic       mon_ok;
        logic       mon_in;
        logic [31:0] exp_b;
        mon_cyc  = 0;
        mon_bits = '0;
        mon_ok   = 1'b1;
        mon_in   = 1'b0;
        forever begin
            tick();
            if (!reset_n) begin
                mon_in = 1'b0;
            end else begin
                if (!mon_in && uart_tx === 1'b0) begin
                    mon_in  = 1'b1;
                    mon_cyc = 0;
                    mon_ok  = 1'b1;
                end
                if (mon_in) begin
                    if (mon_cyc % 10 == 0) mon_bits[4'(mon_cyc / 10)] = uart_tx;
                    else if (uart_tx !== mon_bits[4'(mon_cyc / 10)]) mon_ok = 1'b0;
                    mon_cyc++;
                    if (mon_cyc == 100) begin
                        mon_in = 1'b0;
                        frames++;
                        check("bit_hold", 32'(mon_ok), 32'd1);
                        check("stop_bit", 32'(mon_bits[9]), 32'd1);
                        exp_b = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD;
                        check("frame_byte", 32'(mon_bits[8:1]), exp_b);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int lat, bcnt, gap, f0, tx_bad, busy_bad;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Quiet inputs produce nothing
        tx_bad = 0; busy_bad = 0;
        for (int k = 0; k < 5000; k++) begin
            tick();
            if (uart_tx !== 1'b1) tx_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        check("quiet_tx", 32'(tx_bad), 32'd0);
        check("quiet_busy", 32'(busy_bad), 32'd0);

        // First report: latency and busy window
        f0 = frames;
        score = 16'h1234; state = ST_PLAY;
        push_line(16'h1234, 4'h2);
        lat = -1; bcnt = 0; seen = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (lat < 0 && uart_tx === 1'b0) lat = k;
            if (busy === 1'b1) begin
                bcnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("start_latency", 32'(lat), 32'd2);
        check("busy_len", 32'(bcnt), 32'd1401);
        wait_idle(200);
        check("line1_drained", 32'(sb.size()), 32'd0);
        check("line1_frames", 32'(frames - f0), 32'd14);

        // Change during a report is sent on the following line
        f0 = frames;
        push_line(16'h1234, 4'h2);
        pulse_req();
        repeat (300) tick();
        score = 16'h0050;
        push_line(16'h0050, 4'h2);
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (busy === 1'b0) break;
        end
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            if (uart_tx === 1'b0) break;
            gap++;
            tick();
        end
        check("b2b_gap", 32'(gap), 32'd2);
        wait_idle(2000);
        check("midchg_drained", 32'(sb.size()), 32'd0);
        check("midchg_frames", 32'(frames - f0), 32'd28);

        // Several send_req pulses while busy collapse into one extra line
        f0 = frames;
        push_line(16'h0050, 4'h2);
        pulse_req();
        repeat (200) tick();
        pulse_req();
        repeat (100) tick();
        pulse_req();
        repeat (100) tick();
        pulse_req();
        push_line(16'h0050, 4'h2);
        wait_idle(4000);
        check("multi_req_drained", 32'(sb.size()), 32'd0);
        check("multi_req_frames", 32'(frames - f0), 32'd28);

        // Non-BCD nibbles rendered as hex
        f0 = frames;
        score = 16'h00AF;
        push_line(16'h00AF, 4'h2);
        wait_idle(2000);
        check("hex_drained", 32'(sb.size()), 32'd0);
        check("hex_frames", 32'(frames - f0), 32'd14);

        // Reset in the middle of byte 5
        state = ST_DROP;
        push_line(16'h00AF, 4'h5);
        repeat (452) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        score = '0;
        state = ST_INIT;
        #1;
        check("async_reset_tx", 32'(uart_tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        f0 = frames;
        tx_bad = 0; busy_bad = 0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (uart_tx !== 1'b1) tx_bad++;
            if (busy !== 1'b0) busy_bad++;
        end
        check("post_reset_tx", 32'(tx_bad), 32'd0);
        check("post_reset_busy", 32'(busy_bad), 32'd0);
        check("post_reset_frames", 32'(frames - f0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
